// File: rtl/store_buffer.sv
// ---------------------------------------------------------------------------
// store_buffer
//   Drain side of the in-order store path. MEM allocates one entry per store
//   and receives the entry index, which travels down the pipe and through the
//   ROB. The ROB commits entries by index (strictly in allocation order).
//   Committed entries drain to data memory in order; entries still PENDING
//   are discarded on a flush.
//
//   Entry lifecycle: FREE -> PENDING (alloc) -> COMMITTED (commit) -> FREE
//   (dmem handshake). Three circular pointers: tail (alloc), cmt (next to
//   commit), head (next to drain).
//
// Configuration macro:
//   STORE_BUFFER_FORWARD_EN  defined   : load probe forwards data from the
//                                        youngest fully covering entry.
//                            undefined : load probe only reports stalls.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   alloc_*                  store enqueue (valid/ready, addr, data, size);
//                            alloc_idx_o is the granted index (tail)
//   commit_valid_i/idx_i     ROB retires a store
//   flush_i                  drop all PENDING entries
//   ld_*                     combinational load probe (hit/data/stall)
//   dmem_*                   registered write request to data memory
//   empty_o, full_o          occupancy flags
// ---------------------------------------------------------------------------
module store_buffer #(
   parameter  int DEPTH  = 4,
   parameter  int ADDR_W = 32,
   localparam int IDX_W  = $clog2(DEPTH),
   localparam int CNT_W  = IDX_W + 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              alloc_valid_i,
   output logic              alloc_ready_o,
   input  logic [ADDR_W-1:0] alloc_addr_i,
   input  logic [31:0]       alloc_data_i,
   input  logic [1:0]        alloc_size_i,
   output logic [IDX_W-1:0]  alloc_idx_o,
   input  logic              commit_valid_i,
   input  logic [IDX_W-1:0]  commit_idx_i,
   input  logic              flush_i,
   input  logic              ld_valid_i,
   input  logic [ADDR_W-1:0] ld_addr_i,
   input  logic [3:0]        ld_be_i,
   output logic              ld_hit_o,
   output logic [31:0]       ld_data_o,
   output logic              ld_stall_o,
   output logic              dmem_req_valid_o,
   input  logic              dmem_req_ready_i,
   output logic [ADDR_W-1:0] dmem_addr_o,
   output logic [31:0]       dmem_wdata_o,
   output logic [3:0]        dmem_be_o,
   output logic              empty_o,
   output logic              full_o
);

   typedef enum logic [1:0] {E_FREE = 2'd0, E_PEND = 2'd1, E_CMT = 2'd2} ent_st_e;

   ent_st_e            st_q    [DEPTH];
   ent_st_e            st_d    [DEPTH];
   logic [ADDR_W-3:0]  waddr_q [DEPTH];
   logic [31:0]        data_q  [DEPTH];
   logic [3:0]         be_q    [DEPTH];

   logic [IDX_W-1:0]   tail_q, cmt_q, head_q;
   logic [IDX_W-1:0]   tail_d, cmt_d, head_d;
   logic [CNT_W-1:0]   count_q, count_d;

   logic [3:0]         alloc_be;
   logic [31:0]        alloc_wd;
   logic               alloc_fire, drain_fire;

   // Word address only; byte offset is carried by the byte enables.
   logic               unused_ld_lo;
   assign unused_ld_lo = ^ld_addr_i[1:0];

   assign full_o        = (count_q == CNT_W'(DEPTH));
   assign empty_o       = (count_q == '0);
   assign alloc_ready_o = !full_o;
   assign alloc_idx_o   = tail_q;

   // A flush in the same cycle discards the incoming store.
   assign alloc_fire = alloc_valid_i && alloc_ready_o && !flush_i;
   assign drain_fire = dmem_req_valid_o && dmem_req_ready_i;

   // Lane placement and data replication for sub-word stores.
   always_comb begin
      alloc_be = 4'b1111;
      alloc_wd = alloc_data_i;
      case (alloc_size_i)
         2'b00: begin
            alloc_be = 4'b0001 << alloc_addr_i[1:0];
            alloc_wd = {4{alloc_data_i[7:0]}};
         end
         2'b01: begin
            alloc_be = 4'b0011 << {alloc_addr_i[1], 1'b0};
            alloc_wd = {2{alloc_data_i[15:0]}};
         end
         default: ;
      endcase
   end

   // Next entry state. Ordering matters: commit is applied before the flush
   // so a store retiring in the flush cycle survives.
   always_comb begin
      for (int i = 0; i < DEPTH; i++) st_d[i] = st_q[i];
      if (drain_fire)     st_d[head_q]       = E_FREE;
      if (commit_valid_i) st_d[commit_idx_i] = E_CMT;
      if (flush_i) begin
         for (int i = 0; i < DEPTH; i++)
            if (st_d[i] == E_PEND) st_d[i] = E_FREE;
      end
      if (alloc_fire)     st_d[tail_q]       = E_PEND;

      head_d = head_q + IDX_W'(drain_fire);
      cmt_d  = cmt_q + IDX_W'(commit_valid_i);
      tail_d = flush_i ? cmt_d : (tail_q + IDX_W'(alloc_fire));

      // Occupancy is recounted from the entry states so flush and
      // simultaneous alloc/drain need no special-case arithmetic.
      count_d = '0;
      for (int i = 0; i < DEPTH; i++)
         if (st_d[i] != E_FREE) count_d = count_d + CNT_W'(1);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) st_q[i] <= E_FREE;
         tail_q           <= '0;
         cmt_q            <= '0;
         head_q           <= '0;
         count_q          <= '0;
         dmem_req_valid_o <= 1'b0;
         dmem_addr_o      <= '0;
         dmem_wdata_o     <= '0;
         dmem_be_o        <= '0;
      end else begin
         for (int i = 0; i < DEPTH; i++) st_q[i] <= st_d[i];
         tail_q  <= tail_d;
         cmt_q   <= cmt_d;
         head_q  <= head_d;
         count_q <= count_d;
         // Request register tracks the entry at the next head. Looking at
         // st_d lets a commit issue the following cycle and lets a new head
         // load in the same cycle the previous one hands off.
         if (!dmem_req_valid_o || dmem_req_ready_i) begin
            dmem_req_valid_o <= (st_d[head_d] == E_CMT);
            dmem_addr_o      <= {waddr_q[head_d], 2'b00};
            dmem_wdata_o     <= data_q[head_d];
            dmem_be_o        <= be_q[head_d];
         end
      end
   end

   // Payload storage; only meaningful while the entry is non-FREE.
   always_ff @(posedge clk) begin
      if (alloc_fire) begin
         waddr_q[tail_q] <= alloc_addr_i[ADDR_W-1:2];
         data_q[tail_q]  <= alloc_wd;
         be_q[tail_q]    <= alloc_be;
      end
   end

`ifdef STORE_BUFFER_FORWARD_EN
   logic [IDX_W-1:0] probe_idx;
   logic             probe_found;

   // Walk youngest to oldest; the first covering match supplies data. Any
   // same-word entry that does not cover the load forces a stall.
   always_comb begin
      ld_hit_o    = 1'b0;
      ld_stall_o  = 1'b0;
      ld_data_o   = '0;
      probe_idx   = '0;
      probe_found = 1'b0;
      if (ld_valid_i) begin
         for (int k = 0; k < DEPTH; k++) begin
            probe_idx = tail_q - IDX_W'(k + 1);
            if (st_q[probe_idx] != E_FREE &&
                waddr_q[probe_idx] == ld_addr_i[ADDR_W-1:2]) begin
               if ((be_q[probe_idx] & ld_be_i) != ld_be_i) begin
                  ld_stall_o = 1'b1;
               end else if (!probe_found) begin
                  probe_found = 1'b1;
                  ld_data_o   = data_q[probe_idx];
               end
            end
         end
         ld_hit_o = probe_found && !ld_stall_o;
         if (ld_stall_o) ld_data_o = '0;
      end
   end
`else
   always_comb begin
      ld_hit_o   = 1'b0;
      ld_stall_o = 1'b0;
      ld_data_o  = '0;
      if (ld_valid_i) begin
         for (int k = 0; k < DEPTH; k++)
            if (st_q[k] != E_FREE &&
                waddr_q[k] == ld_addr_i[ADDR_W-1:2] &&
                (be_q[k] & ld_be_i) != 4'b0000)
               ld_stall_o = 1'b1;
      end
   end
`endif

`ifndef SYNTHESIS
   // ROB must retire strictly in order and only PENDING entries.
   always_ff @(posedge clk) begin
      if (!rst && commit_valid_i) begin
         a_commit_order: assert (commit_idx_i == cmt_q && st_q[commit_idx_i] == E_PEND);
      end
   end
`endif

endmodule
